instr_field_split_reg: RTL

//  Inverse of the field-concatenation path: accepts a 32-bit MIPS instruction word plus its PC.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/instr_field_decode.sv | 59 +++++
 rtl/instr_field_split_reg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions.
// Holds the opcode values that select the instruction class and the bit
// positions and widths of each field. It also defines the instruction-type and
// skid-buffer state encodings and a classifier helper. The decoder and the
// top-level buffer both import this package.
package mips_pkg;

    // Opcodes that select the R- and J-type instruction classes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Field bit positions (LSB) and widths within the 32-bit word
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int REG_W      = 5;
    localparam int SHAMT_LSB  = 6;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;
    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = 26;

    // Instruction class encoding
    typedef enum logic [1:0] {
        INSTR_R = 2'd0,
        INSTR_I = 2'd1,
        INSTR_J = 2'd2
    } instr_type_e;

    // Skid-buffer occupancy: nothing, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Map an opcode onto its instruction class
    function automatic instr_type_e classify(input logic [5:0] op);
        instr_type_e t;
        case (op)
            OP_RTYPE:      t = INSTR_R;
            OP_J, OP_JAL:  t = INSTR_J;
            default:       t = INSTR_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational MIPS field splitter.
// Ports:
//   instr        in   32        instruction word
//   pc           in   PC_WIDTH  address of instr
//   opcode .. funct out         raw fields
//   imm_sext/imm_zext out 32    sign/zero-extended 16-bit immediate
//   pc_plus4     out  PC_WIDTH  pc + 4 (wraps)
//   jump_target  out  PC_WIDTH  {pc_plus4[top], target, 2'b00}
//   is_rtype/is_jtype/is_itype  one-hot class
//   is_nop       out  1         instr is all zeros
module instr_field_decode
    import mips_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [31:0]         instr,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [5:0]          opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          funct,
    output logic [31:0]         imm_sext,
    output logic [31:0]         imm_zext,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] jump_target,
    output logic                is_rtype,
    output logic                is_jtype,
    output logic                is_itype,
    output logic                is_nop
);

    // Low 28 address bits come from the jump field; the rest from pc_plus4
    localparam logic [PC_WIDTH-1:0] LOW_MASK = PC_WIDTH'({28{1'b1}});

    instr_type_e type_s;

    // Split the word into fields and derive immediates, targets and class
    always_comb begin
        opcode      = instr[OPCODE_LSB +: OPCODE_W];
        rs          = instr[RS_LSB +: REG_W];
        rt          = instr[RT_LSB +: REG_W];
        rd          = instr[RD_LSB +: REG_W];
        shamt       = instr[SHAMT_LSB +: SHAMT_W];
        funct       = instr[FUNCT_LSB +: FUNCT_W];
        imm_sext    = {{16{instr[IMM_LSB + IMM_W - 1]}}, instr[IMM_LSB +: IMM_W]};
        imm_zext    = {16'h0000, instr[IMM_LSB +: IMM_W]};
        pc_plus4    = pc + PC_WIDTH'(32'd4);
        jump_target = (pc_plus4 & ~LOW_MASK) |
                      PC_WIDTH'({instr[TARGET_LSB +: TARGET_W], 2'b00});
        type_s      = classify(instr[OPCODE_LSB +: OPCODE_W]);
        is_rtype    = (type_s == INSTR_R);
        is_jtype    = (type_s == INSTR_J);
        is_itype    = (type_s == INSTR_I);
        is_nop      = (instr == 32'h0000_0000);
    end

endmodule

// File: rtl/instr_field_split_reg.sv
// Fetch-to-decode register: a 2-entry skid buffer that splits the MIPS word.
// Ports:
//   clk, rst_n (sync, active-low), flush (drops all buffered beats)
//   in_valid/in_ready/instr_in/pc_in      upstream handshake and beat
//   out_valid/out_ready                   downstream handshake
//   opcode, rs, rt, rd, shamt, funct, imm_sext, imm_zext, pc_plus4,
//   jump_target, is_rtype/is_jtype/is_itype, is_nop   decoded main entry
//   flush_drop_cnt                        saturating count of flushed beats
// The main entry is kept in decoded form. Each beat is split once as it
// enters main, so every output comes straight from a flop. Only the raw
// skid beat is stored undecoded.
module instr_field_split_reg
    import mips_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr_in,
    input  logic [PC_WIDTH-1:0]  pc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           opcode,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           shamt,
    output logic [5:0]           funct,
    output logic [31:0]          imm_sext,
    output logic [31:0]          imm_zext,
    output logic [PC_WIDTH-1:0]  pc_plus4,
    output logic [PC_WIDTH-1:0]  jump_target,
    output logic                 is_rtype,
    output logic                 is_jtype,
    output logic                 is_itype,
    output logic                 is_nop,
    output logic [CNT_WIDTH-1:0] flush_drop_cnt
);

    localparam int SUM_W = CNT_WIDTH + 1;

    // Add 0..2 dropped beats, sticking at all-ones
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] b);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + SUM_W'(b);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    skid_state_e          state_r, state_nx_s;
    logic                 in_ready_r, out_valid_r;
    logic [31:0]          skid_instr_r;
    logic [PC_WIDTH-1:0]  skid_pc_r;
    logic [CNT_WIDTH-1:0] drop_cnt_r;
    logic                 accept_s, consume_s, load_main_s, load_skid_s;
    logic [1:0]           drop_s;
    logic [31:0]          dec_instr_s;
    logic [PC_WIDTH-1:0]  dec_pc_s;

    logic [5:0]          opcode_r, dec_opcode_s;
    logic [4:0]          rs_r, rt_r, rd_r, shamt_r, dec_rs_s, dec_rt_s, dec_rd_s, dec_shamt_s;
    logic [5:0]          funct_r, dec_funct_s;
    logic [31:0]         imm_sext_r, imm_zext_r, dec_imm_sext_s, dec_imm_zext_s;
    logic [PC_WIDTH-1:0] pc_plus4_r, jump_target_r, dec_pc_plus4_s, dec_jump_target_s;
    logic                is_rtype_r, is_jtype_r, is_itype_r, is_nop_r;
    logic                dec_is_rtype_s, dec_is_jtype_s, dec_is_itype_s, dec_is_nop_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = out_valid_r & out_ready;

    // When main refills with a skid beat pending, the skid beat goes first
    assign dec_instr_s = (state_r == ST_TWO) ? skid_instr_r : instr_in;
    assign dec_pc_s    = (state_r == ST_TWO) ? skid_pc_r    : pc_in;

    instr_field_decode #(.PC_WIDTH(PC_WIDTH)) u_decode (
        .instr       (dec_instr_s),
        .pc          (dec_pc_s),
        .opcode      (dec_opcode_s),
        .rs          (dec_rs_s),
        .rt          (dec_rt_s),
        .rd          (dec_rd_s),
        .shamt       (dec_shamt_s),
        .funct       (dec_funct_s),
        .imm_sext    (dec_imm_sext_s),
        .imm_zext    (dec_imm_zext_s),
        .pc_plus4    (dec_pc_plus4_s),
        .jump_target (dec_jump_target_s),
        .is_rtype    (dec_is_rtype_s),
        .is_jtype    (dec_is_jtype_s),
        .is_itype    (dec_is_itype_s),
        .is_nop      (dec_is_nop_s)
    );

    // Next occupancy, entry load strobes and flush drop amount
    always_comb begin
        state_nx_s  = state_r;
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        drop_s      = 2'd0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
            case (state_r)
                ST_ONE:  drop_s = 2'd1;
                ST_TWO:  drop_s = 2'd2;
                default: drop_s = 2'd0;
            endcase
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nx_s  = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nx_s  = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (consume_s && accept_s) begin
                        state_nx_s  = ST_ONE;
                        load_main_s = 1'b1;
                    end else if (consume_s) begin
                        state_nx_s  = ST_EMPTY;
                    end else if (accept_s) begin
                        state_nx_s  = ST_TWO;
                        load_skid_s = 1'b1;
                    end else begin
                        state_nx_s  = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so no beat can be accepted
                    if (consume_s) begin
                        state_nx_s  = ST_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        state_nx_s  = ST_TWO;
                    end
                end
                default: state_nx_s = ST_EMPTY;
            endcase
        end
    end

    // Buffer state, entries, handshake flags and drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_EMPTY;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            skid_instr_r  <= 32'h0000_0000;
            skid_pc_r     <= '0;
            drop_cnt_r    <= '0;
            opcode_r      <= 6'd0;
            rs_r          <= 5'd0;
            rt_r          <= 5'd0;
            rd_r          <= 5'd0;
            shamt_r       <= 5'd0;
            funct_r       <= 6'd0;
            imm_sext_r    <= 32'h0000_0000;
            imm_zext_r    <= 32'h0000_0000;
            pc_plus4_r    <= '0;
            jump_target_r <= '0;
            is_rtype_r    <= 1'b0;
            is_jtype_r    <= 1'b0;
            is_itype_r    <= 1'b0;
            is_nop_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != ST_TWO);
            out_valid_r <= (state_nx_s != ST_EMPTY);
            drop_cnt_r  <= sat_add(drop_cnt_r, drop_s);
            if (load_skid_s) begin
                skid_instr_r <= instr_in;
                skid_pc_r    <= pc_in;
            end
            if (load_main_s) begin
                opcode_r      <= dec_opcode_s;
                rs_r          <= dec_rs_s;
                rt_r          <= dec_rt_s;
                rd_r          <= dec_rd_s;
                shamt_r       <= dec_shamt_s;
                funct_r       <= dec_funct_s;
                imm_sext_r    <= dec_imm_sext_s;
                imm_zext_r    <= dec_imm_zext_s;
                pc_plus4_r    <= dec_pc_plus4_s;
                jump_target_r <= dec_jump_target_s;
                is_rtype_r    <= dec_is_rtype_s;
                is_jtype_r    <= dec_is_jtype_s;
                is_itype_r    <= dec_is_itype_s;
                is_nop_r      <= dec_is_nop_s;
            end
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign flush_drop_cnt = drop_cnt_r;
    assign opcode         = opcode_r;
    assign rs             = rs_r;
    assign rt             = rt_r;
    assign rd             = rd_r;
    assign shamt          = shamt_r;
    assign funct          = funct_r;
    assign imm_sext       = imm_sext_r;
    assign imm_zext       = imm_zext_r;
    assign pc_plus4       = pc_plus4_r;
    assign jump_target    = jump_target_r;
    assign is_rtype       = is_rtype_r;
    assign is_jtype       = is_jtype_r;
    assign is_itype       = is_itype_r;
    assign is_nop         = is_nop_r;

endmodule
